// File: rtl/bsg_manycore_wh_ruche_link_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bsg_manycore_wh_ruche_link_pipe_pkg
// Brief    : Direction indices, link width and lane-rotation helper for the WH ruche pipe
// Revision : 1.0
// ============================================================================
package bsg_manycore_wh_ruche_link_pipe_pkg;

    // Same numbering as the manycore NoC direction enum (P=0, W=1, E=2, ...)
    localparam int c_dir_w = 1;
    localparam int c_dir_e = 2;

    // Link layout is {v, ready_and_rev, data}
    function automatic int link_sif_width(input int flit_width);
        return flit_width + 2;
    endfunction

    function automatic int ruche_out_lane(input int lane, input int factor,
                                          input bit eastbound, input bit rotate);
        if (!rotate) return lane;
        return eastbound ? (lane + 1) % factor : (lane + factor - 1) % factor;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_manycore_wh_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : bsg_manycore_wh_pipe_stage
// Brief    : 2-entry ready_and FIFO carrying one WH channel at full throughput
// Revision : 1.0
// ============================================================================
module bsg_manycore_wh_pipe_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             v_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             v_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ready_i
);

    logic             r_live;
    logic [1:0]       r_count;
    logic             r_wptr;
    logic             r_rptr;
    logic [WIDTH-1:0] r_mem [2];
    logic             w_enq;
    logic             w_deq;

    assign w_enq = v_i & ready_o;
    assign w_deq = v_o & ready_i;

    // r_live keeps ready low while reset is held and for no longer
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_live  <= 1'b0;
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
            if (w_enq) r_wptr <= ~r_wptr;
            if (w_deq) r_rptr <= ~r_rptr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) r_mem[r_wptr] <= data_i;
    end

    assign ready_o = r_live & (r_count != 2'd2);
    assign v_o     = (r_count != 2'd0);
    assign data_o  = r_mem[r_rptr];

endmodule
`default_nettype wire

// File: rtl/bsg_manycore_wh_ruche_link_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bsg_manycore_wh_ruche_link_pipe
// Brief    : Registered, optionally rotating WH ruche link pipe with per-row flit counters
// Revision : 1.0
// ============================================================================
module bsg_manycore_wh_ruche_link_pipe
    import bsg_manycore_wh_ruche_link_pipe_pkg::*;
#(
    parameter int wh_flit_width_p   = 16,
    parameter int num_vcache_rows_p = 1,
    parameter int wh_ruche_factor_p = 2,
    parameter int pipe_depth_p      = 1,
    parameter int rotate_p          = 1,
    parameter int count_width_p     = 16,
    localparam int wh_link_sif_width_lp = link_sif_width(wh_flit_width_p)
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic [num_vcache_rows_p-1:0][wh_ruche_factor_p-1:0][wh_link_sif_width_lp-1:0] w_link_sif_i,
    output logic [num_vcache_rows_p-1:0][wh_ruche_factor_p-1:0][wh_link_sif_width_lp-1:0] w_link_sif_o,
    input  logic [num_vcache_rows_p-1:0][wh_ruche_factor_p-1:0][wh_link_sif_width_lp-1:0] e_link_sif_i,
    output logic [num_vcache_rows_p-1:0][wh_ruche_factor_p-1:0][wh_link_sif_width_lp-1:0] e_link_sif_o,
    input  logic ctr_clear_i,
    output logic [c_dir_e:c_dir_w][num_vcache_rows_p-1:0][count_width_p-1:0] flit_count_o
);

    localparam int c_fw    = wh_flit_width_p;
    localparam int c_rows  = num_vcache_rows_p;
    localparam int c_rf    = wh_ruche_factor_p;
    localparam int c_inc_w = $clog2(c_rf + 1);

    // First index: 0 = eastbound, 1 = westbound
    logic            w_in_v      [2][c_rows][c_rf];
    logic [c_fw-1:0] w_in_data   [2][c_rows][c_rf];
    logic            w_in_ready  [2][c_rows][c_rf];
    logic            w_out_v     [2][c_rows][c_rf];
    logic [c_fw-1:0] w_out_data  [2][c_rows][c_rf];
    logic            w_out_ready [2][c_rows][c_rf];

    for (genvar r = 0; r < c_rows; r++) begin : g_link_row
        for (genvar l = 0; l < c_rf; l++) begin : g_link_lane
            assign w_in_v[0][r][l]      = w_link_sif_i[r][l][c_fw+1];
            assign w_out_ready[1][r][l] = w_link_sif_i[r][l][c_fw];
            assign w_in_data[0][r][l]   = w_link_sif_i[r][l][c_fw-1:0];
            assign w_in_v[1][r][l]      = e_link_sif_i[r][l][c_fw+1];
            assign w_out_ready[0][r][l] = e_link_sif_i[r][l][c_fw];
            assign w_in_data[1][r][l]   = e_link_sif_i[r][l][c_fw-1:0];
            assign w_link_sif_o[r][l]   = {w_out_v[1][r][l], w_in_ready[0][r][l], w_out_data[1][r][l]};
            assign e_link_sif_o[r][l]   = {w_out_v[0][r][l], w_in_ready[1][r][l], w_out_data[0][r][l]};
        end
    end

    for (genvar d = 0; d < 2; d++) begin : g_dir
        for (genvar r = 0; r < c_rows; r++) begin : g_row
            for (genvar l = 0; l < c_rf; l++) begin : g_lane
                localparam int c_lo = ruche_out_lane(l, c_rf, d == 0, rotate_p != 0);

                if (pipe_depth_p == 0) begin : g_wire
                    // Gate the pass-through so nothing looks valid or ready during reset
                    logic r_live;
                    always_ff @(posedge clk_i or negedge reset_n_i) begin
                        if (!reset_n_i) r_live <= 1'b0;
                        else            r_live <= 1'b1;
                    end
                    assign w_out_v[d][r][c_lo]    = w_in_v[d][r][l] & r_live;
                    assign w_out_data[d][r][c_lo] = w_in_data[d][r][l];
                    assign w_in_ready[d][r][l]    = w_out_ready[d][r][c_lo] & r_live;
                end else begin : g_pipe
                    logic            w_v   [pipe_depth_p+1];
                    logic            w_rdy [pipe_depth_p+1];
                    logic [c_fw-1:0] w_dat [pipe_depth_p+1];

                    assign w_v[0]                     = w_in_v[d][r][l];
                    assign w_dat[0]                   = w_in_data[d][r][l];
                    assign w_in_ready[d][r][l]        = w_rdy[0];
                    assign w_out_v[d][r][c_lo]        = w_v[pipe_depth_p];
                    assign w_out_data[d][r][c_lo]     = w_dat[pipe_depth_p];
                    assign w_rdy[pipe_depth_p]        = w_out_ready[d][r][c_lo];

                    for (genvar s = 0; s < pipe_depth_p; s++) begin : g_stage
                        bsg_manycore_wh_pipe_stage #(.WIDTH(c_fw)) u_stage (
                            .clk_i     (clk_i),
                            .reset_n_i (reset_n_i),
                            .v_i       (w_v[s]),
                            .data_i    (w_dat[s]),
                            .ready_o   (w_rdy[s]),
                            .v_o       (w_v[s+1]),
                            .data_o    (w_dat[s+1]),
                            .ready_i   (w_rdy[s+1])
                        );
                    end
                end
            end
        end
    end

    for (genvar d = 0; d < 2; d++) begin : g_cnt_dir
        for (genvar r = 0; r < c_rows; r++) begin : g_cnt_row
            logic [c_inc_w-1:0]       w_inc;
            logic [count_width_p-1:0] r_count;

            always_comb begin
                w_inc = '0;
                for (int l = 0; l < c_rf; l++) begin
                    w_inc = w_inc + c_inc_w'(w_out_v[d][r][l] & w_out_ready[d][r][l]);
                end
            end

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i)       r_count <= '0;
                else if (ctr_clear_i) r_count <= '0;
                else                  r_count <= r_count + count_width_p'(w_inc);
            end

            assign flit_count_o[(d == 0) ? c_dir_e : c_dir_w][r] = r_count;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bsg_manycore_wh_ruche_link_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_manycore_wh_ruche_link_pipe
// Brief    : Scoreboard bench over three pipe configurations (depth 2 / 0 / 3)
// Revision : 1.0
// ============================================================================
module tb_bsg_manycore_wh_ruche_link_pipe;
    import bsg_manycore_wh_ruche_link_pipe_pkg::*;

    localparam int FW   = 8;
    localparam int ROWS = 2;
    localparam int RF   = 3;
    localparam int NCH  = 2 * ROWS * RF;
    localparam int SW   = FW + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_v    [3][NCH];
    logic [FW-1:0] in_d    [3][NCH];
    logic          out_rdy [3][NCH];
    logic          out_v   [3][NCH];
    logic [FW-1:0] out_d   [3][NCH];
    logic          in_rdy  [3][NCH];
    logic          clr     [3];
    logic [15:0]   cnt     [3][2][ROWS];

    int sb    [3*NCH][$];
    int cnt_m [3][2][ROWS];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_rdy = 1'b0;
    bit chk_lat = 1'b0;

    function automatic int chan(int d, int r, int l);
        return d * ROWS * RF + r * RF + l;
    endfunction

    function automatic int out_chan(int ch);
        int d  = ch / (ROWS * RF);
        int r  = (ch / RF) % ROWS;
        int l  = ch % RF;
        int lo = (d == 0) ? (l + 1) % RF : (l + RF - 1) % RF;
        return chan(d, r, lo);
    endfunction

    function automatic int depth_of(int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
    endfunction

    function automatic int cw_of(int k);
        return (k == 0) ? 4 : 16;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int DEP = (k == 0) ? 2 : ((k == 1) ? 0 : 3);
        localparam int CWD = (k == 0) ? 4 : 16;
        logic [ROWS-1:0][RF-1:0][SW-1:0] wi, wo, ei, eo;
        logic [c_dir_e:c_dir_w][ROWS-1:0][CWD-1:0] fc;

        bsg_manycore_wh_ruche_link_pipe #(
            .wh_flit_width_p   (FW),
            .num_vcache_rows_p (ROWS),
            .wh_ruche_factor_p (RF),
            .pipe_depth_p      (DEP),
            .rotate_p          (1),
            .count_width_p     (CWD)
        ) dut (
            .clk_i        (clk),
            .reset_n_i    (rst_n),
            .w_link_sif_i (wi),
            .w_link_sif_o (wo),
            .e_link_sif_i (ei),
            .e_link_sif_o (eo),
            .ctr_clear_i  (clr[k]),
            .flit_count_o (fc)
        );

        for (genvar r = 0; r < ROWS; r++) begin : g_r
            assign cnt[k][0][r] = 16'(fc[c_dir_e][r]);
            assign cnt[k][1][r] = 16'(fc[c_dir_w][r]);
            for (genvar l = 0; l < RF; l++) begin : g_l
                localparam int CE = r * RF + l;
                localparam int CX = ROWS * RF + r * RF + l;
                assign wi[r][l]     = {in_v[k][CE], out_rdy[k][CX], in_d[k][CE]};
                assign ei[r][l]     = {in_v[k][CX], out_rdy[k][CE], in_d[k][CX]};
                assign out_v[k][CE] = eo[r][l][FW+1];
                assign in_rdy[k][CX] = eo[r][l][FW];
                assign out_d[k][CE] = eo[r][l][FW-1:0];
                assign out_v[k][CX] = wo[r][l][FW+1];
                assign in_rdy[k][CE] = wo[r][l][FW];
                assign out_d[k][CX] = wo[r][l][FW-1:0];
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int any_v();
        int a = 0;
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < NCH; c++) if (out_v[k][c] !== 1'b0) a = 1;
        return a;
    endfunction

    function automatic int any_rdy();
        int a = 0;
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < NCH; c++) if (in_rdy[k][c] !== 1'b0) a = 1;
        return a;
    endfunction

    function automatic int all_rdy();
        int a = 1;
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < NCH; c++) if (in_rdy[k][c] !== 1'b1) a = 0;
        return a;
    endfunction

    function automatic int any_cnt();
        int a = 0;
        for (int k = 0; k < 3; k++)
            for (int d = 0; d < 2; d++)
                for (int r = 0; r < ROWS; r++) if (cnt[k][d][r] !== 16'd0) a = 1;
        return a;
    endfunction

    // One clock: sample handshakes at negedge, update scoreboard/counter model, drive after posedge
    task automatic tick();
        int deliv [3][2][ROWS];
        int oc;
        int e;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < NCH; c++) begin
                oc = k * NCH + out_chan(c);
                if (chk_rdy) begin
                    if (depth_of(k) == 0)
                        check_val("rdy_pass", 32'(in_rdy[k][c]), 32'(out_rdy[k][out_chan(c)]));
                    else if (sb[oc].size() < 2)
                        check_val("rdy_free", 32'(in_rdy[k][c]), 32'd1);
                end
                if (in_v[k][c] && in_rdy[k][c]) sb[oc].push_back(cyc * 256 + int'(in_d[k][c]));
            end
        end
        for (int k = 0; k < 3; k++)
            for (int d = 0; d < 2; d++)
                for (int r = 0; r < ROWS; r++) deliv[k][d][r] = 0;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if (out_v[k][c] && out_rdy[k][c]) begin
                    deliv[k][c / (ROWS * RF)][(c / RF) % ROWS]++;
                    if (sb[k * NCH + c].size() == 0) begin
                        check_val("extra_flit", 32'(sb[k * NCH + c].size()), 32'd1);
                    end else begin
                        e = sb[k * NCH + c].pop_front();
                        check_val("data", 32'(out_d[k][c]), 32'(e & 255));
                        if (chk_lat) check_val("latency", 32'(cyc - e / 256), 32'(depth_of(k)));
                    end
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            for (int d = 0; d < 2; d++) begin
                for (int r = 0; r < ROWS; r++) begin
                    check_val("flit_count", 32'(cnt[k][d][r]), 32'(cnt_m[k][d][r]));
                    if (!rst_n || clr[k]) cnt_m[k][d][r] = 0;
                    else cnt_m[k][d][r] = (cnt_m[k][d][r] + deliv[k][d][r]) & ((1 << cw_of(k)) - 1);
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_check(input string tag);
        for (int i = 0; i < 3 * NCH; i++) begin
            check_val(tag, 32'(sb[i].size()), 32'd0);
            sb[i].delete();
        end
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 3; k++) begin
            clr[k] = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                in_v[k][c]    = 1'b0;
                out_rdy[k][c] = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            clr[k] = 1'b0;
            for (int d = 0; d < 2; d++)
                for (int r = 0; r < ROWS; r++) cnt_m[k][d][r] = 0;
            for (int c = 0; c < NCH; c++) begin
                in_v[k][c]    = 1'b1;
                in_d[k][c]    = 8'($urandom);
                out_rdy[k][c] = 1'b1;
            end
        end

        // Reset held with valid inputs
        repeat (5) begin
            @(negedge clk);
            check_val("rst_v", 32'(any_v()), 32'd0);
            check_val("rst_rdy", 32'(any_rdy()), 32'd0);
            check_val("rst_cnt", 32'(any_cnt()), 32'd0);
        end
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rdy_after_rst", 32'(all_rdy()), 32'd1);
        chk_rdy = 1'b1;

        // Lane rotation on all three configurations, exact latency
        chk_lat = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_v[k][chan(0, 0, 0)] = 1'b1; in_d[k][chan(0, 0, 0)] = 8'hA5;
            in_v[k][chan(1, 0, 0)] = 1'b1; in_d[k][chan(1, 0, 0)] = 8'h5A;
            in_v[k][chan(0, 1, 2)] = 1'b1; in_d[k][chan(0, 1, 2)] = 8'h3C;
            in_v[k][chan(1, 1, 1)] = 1'b1; in_d[k][chan(1, 1, 1)] = 8'hC3;
        end
        tick();
        idle_inputs();
        repeat (5) tick();
        drain_check("rot_drain");

        // Depth-3 throughput: 100 back-to-back flits
        clr[2] = 1'b1;
        tick();
        clr[2] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            in_v[2][chan(0, 0, 0)] = 1'b1;
            in_d[2][chan(0, 0, 0)] = 8'(i);
            tick();
        end
        idle_inputs();
        repeat (6) tick();
        drain_check("thru_drain");
        check_val("cnt100", 32'(cnt[2][0][0]), 32'd100);

        // 4-bit counter wrap, then clear in a two-delivery cycle
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_v[0][chan(0, 0, 0)] = 1'b1;
            in_d[0][chan(0, 0, 0)] = 8'(i + 32);
            tick();
        end
        idle_inputs();
        repeat (5) tick();
        check_val("wrap17", 32'(cnt[0][0][0]), 32'd1);
        in_v[0][chan(0, 0, 0)] = 1'b1; in_d[0][chan(0, 0, 0)] = 8'h11;
        in_v[0][chan(0, 0, 1)] = 1'b1; in_d[0][chan(0, 0, 1)] = 8'h22;
        tick();
        idle_inputs();
        tick();
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        check_val("clr_2lane", 32'(cnt[0][0][0]), 32'd0);
        repeat (3) tick();
        drain_check("clr_drain");

        // Random traffic with 30% downstream ready
        chk_lat = 1'b0;
        repeat (400) begin
            for (int k = 0; k < 3; k++) begin
                clr[k] = ($urandom_range(0, 49) == 0);
                for (int c = 0; c < NCH; c++) begin
                    in_v[k][c]    = 1'($urandom_range(0, 1));
                    in_d[k][c]    = 8'($urandom);
                    out_rdy[k][c] = ($urandom_range(0, 9) < 3);
                end
            end
            tick();
        end
        idle_inputs();
        repeat (10) tick();
        drain_check("bp_drain");

        // Reset while 4 flits sit in the depth-2 pipe
        for (int c = 0; c < NCH; c++) out_rdy[0][c] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_v[0][chan(0, 0, 0)] = 1'b1;
            in_d[0][chan(0, 0, 0)] = 8'(i + 16);
            tick();
        end
        in_v[0][chan(0, 0, 0)] = 1'b0;
        tick();
        check_val("buffered4", 32'(sb[out_chan(chan(0, 0, 0))].size()), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_v", 32'(any_v()), 32'd0);
        check_val("mid_rst_rdy", 32'(any_rdy()), 32'd0);
        check_val("mid_rst_cnt", 32'(any_cnt()), 32'd0);
        for (int i = 0; i < 3 * NCH; i++) sb[i].delete();
        for (int k = 0; k < 3; k++)
            for (int d = 0; d < 2; d++)
                for (int r = 0; r < ROWS; r++) cnt_m[k][d][r] = 0;
        chk_rdy = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk_rdy = 1'b1;
        repeat (6) tick();
        drain_check("post_rst_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bsg_manycore_wh_ruche_link_pipe.md
Name: bsg_manycore_wh_ruche_link_pipe

Overview:
Parametrised, registered ruche link pipe for the wormhole (WH) links between vcache subarrays, and between subarrays and the IO/DRAM edge.
- Generalises the purely combinational ruche buffering: configurable pipeline depth, row count and ruche factor.
- Each channel gets elastic 2-entry buffering with full throughput.
- Adds a ruche rotation mode and per-row, per-direction flit counters.
- Placed on long WH runs so cross-subarray links meet timing without changing the ruche lane semantics.

Parameters:
- wh_flit_width_p, none (required), WH flit width in bits.
- num_vcache_rows_p, 1, vcache rows carried by the pipe.
- wh_ruche_factor_p, 2, ruche lanes per row per direction.
- pipe_depth_p, 1, registered stages per channel; 0 means combinational pass-through.
- rotate_p, 1, 1 = apply ruche lane rotation once across the pipe; 0 = lanes map straight through.
- count_width_p, 16, width of each flit counter.
- wh_link_sif_width_lp, localparam, `bsg_ready_and_link_sif_width(wh_flit_width_p).

Ports:
- clk_i  in  1  single clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- w_link_sif_i  in  [num_vcache_rows_p][wh_ruche_factor_p][wh_link_sif_width_lp]  west side: eastbound v/data in, ready_and_rev for westbound.
- w_link_sif_o  out  same  west side: westbound v/data out, ready_and_rev for eastbound.
- e_link_sif_i  in  same  east side: westbound v/data in, ready_and_rev for eastbound.
- e_link_sif_o  out  same  east side: eastbound v/data out, ready_and_rev for westbound.
- ctr_clear_i  in  1  synchronous clear of all flit counters.
- flit_count_o  out  [E:W][num_vcache_rows_p][count_width_p]  flits delivered per direction per row, summed over lanes.

Behaviour:
- Channels and lanes:
  - Independent channels: 2 directions x num_vcache_rows_p x wh_ruche_factor_p. There is no cross-channel interaction except the counter sum.
  - Lane mapping with rotate_p=1 and R = wh_ruche_factor_p: eastbound input lane l exits on lane (l+1)%R; westbound input lane l exits on lane (l+R-1)%R.
  - With rotate_p=0, lane l exits on lane l.
  - With R=1, rotation is the identity.
- Stage: one 2-entry FIFO with ready_and handshake.
  - Accepts a flit when v_i & ready_o; ready_o = not full.
  - v_o = not empty.
  - A flit is delivered on v_o & ready_i.
  - Simultaneous enqueue and dequeue when one entry is occupied keeps occupancy at 1.
  - Enqueue while full is impossible, since ready_o=0.
- Latency and throughput:
  - Latency is pipe_depth_p cycles from input handshake to earliest output valid.
  - Sustained 1 flit/cycle per channel when downstream is always ready.
  - pipe_depth_p=0: v, data and ready wired through with rotation only, zero latency, no storage.
- Ordering and backpressure:
  - Flit order is preserved per channel.
  - No flit is dropped or duplicated under arbitrary backpressure.
  - Wormhole headers and bodies are not interpreted.
- Reset:
  - reset_n_i low asynchronously empties all stages and zeros all counters.
  - While reset_n_i is low, every output v = 0, every ready_and_rev = 0, and flit_count_o = 0.
  - On the first clk_i edge after deassertion, ready_and_rev = 1 (stages empty).
  - Reset mid-packet discards all buffered flits; upstream and downstream are reset together.
- Counters:
  - flit_count_o[d][r] increments on each cycle by the number of lanes of row r delivering a flit at the pipe output in direction d (0..R).
  - Counters wrap modulo 2^count_width_p.
  - ctr_clear_i has priority: when it is asserted, the counter becomes 0 and that cycle's deliveries are not counted.
  - With pipe_depth_p=0, the counters count pass-through handshakes.
- Width rule: the increment is zero-extended to count_width_p before addition.

Decomposition:
- Link struct: use `declare_bsg_ready_and_link_sif_s from the existing manycore defines; no new package types.
- Direction indices: E/W from bsg_noc_pkg.
- Sub-module bsg_manycore_wh_pipe_stage: a single 2-entry ready_and FIFO, width wh_flit_width_p, async active-low reset.
- Top-level contents: rotation wiring, generate chains of pipe_depth_p stages, counters.

Test Plan:
- Reset: hold reset_n_i low 5 cycles with inputs driving v=1 -> all v outputs 0, ready 0, counts 0; after release, ready=1 next cycle.
- Rotation: R=2, depth=1, rotate_p=1; eastbound flit 0xA5 on row 0 lane 0 -> appears on e_link_sif_o lane 1 one cycle later; westbound lane 0 -> w_link_sif_o lane 1.
- Throughput: depth=3, 100 consecutive flits 0..99 on one channel with ready always 1 -> outputs 0..99 in order, first at cycle 3, one per cycle, flit_count_o[E][0]=100.
- Backpressure: random downstream ready at 30% with random source -> scoreboard order intact; input ready drops only when the first stage is full.
- Counters: count_width_p=4, 17 deliveries -> count reads 1 (wrap); ctr_clear_i asserted in a cycle with 2 lane deliveries -> count 0 next cycle.
- Depth 0 and mid-traffic reset: depth=0 gives same-cycle pass-through with rotation; depth=2 with reset asserted while 4 flits are buffered -> all outputs v=0 immediately, nothing is emitted after release.
